// File: rtl/mmio_ui_ctrl.sv
// mmio_ui_ctrl: memory-mapped UI block for the single-cycle core.
// Owns the HEX nibble and LEDR registers, synchronises KEY/SW, debounces
// the switches and keeps sticky ready/overrun status for key presses and
// switch changes so software can poll for edges instead of levels.
module mmio_ui_ctrl #(
  parameter int                DBITS           = 32,
  parameter int                N_KEYS          = 4,
  parameter int                N_SW            = 10,
  parameter int                N_LEDR          = 10,
  parameter int                N_HEX           = 4,
  parameter int                DEBOUNCE_CYCLES = 16,
  parameter logic [DBITS-1:0]  ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0]  ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0]  ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0]  ADDR_SCTRL      = 32'hF0000114
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DBITS-1:0]     addr,
  input  logic [DBITS-1:0]     wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [DBITS-1:0]     rdata,
  output logic                 hit,
  input  logic [N_KEYS-1:0]    KEY,
  input  logic [N_SW-1:0]      SW,
  output logic [N_LEDR-1:0]    LEDR,
  output logic [7*N_HEX-1:0]   HEX
);

  // Counter just wide enough to hold DEBOUNCE_CYCLES-1 (at least one bit).
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic selHex, selLedr, selKey, selSw, selKctrl, selSctrl;

  assign selHex   = (addr == ADDR_HEX);
  assign selLedr  = (addr == ADDR_LEDR);
  assign selKey   = (addr == ADDR_KEY);
  assign selSw    = (addr == ADDR_SW);
  assign selKctrl = (addr == ADDR_KCTRL);
  assign selSctrl = (addr == ADDR_SCTRL);
  assign hit      = selHex | selLedr | selKey | selSw | selKctrl | selSctrl;

  // Only wdata[2] matters for the status registers; the upper store bits
  // are simply dropped for the narrower registers.
  logic unusedBits;
  assign unusedBits = ^wdata;

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  logic [4*N_HEX-1:0] hexReg;
  logic [N_LEDR-1:0]  ledrReg;

  // Stores to HEX/LEDR take the low bits of wdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      hexReg  <= '0;
      ledrReg <= '0;
    end else begin
      if (we && selHex)  hexReg  <= wdata[4*N_HEX-1:0];
      if (we && selLedr) ledrReg <= wdata[N_LEDR-1:0];
    end
  end

  assign LEDR = ledrReg;

  // Active-low 7-segment glyph for one hex nibble, segment g in bit 6.
  function automatic logic [6:0] hexGlyph(input logic [3:0] nib);
    case (nib)
      4'h0: hexGlyph = 7'b1000000;
      4'h1: hexGlyph = 7'b1111001;
      4'h2: hexGlyph = 7'b0100100;
      4'h3: hexGlyph = 7'b0110000;
      4'h4: hexGlyph = 7'b0011001;
      4'h5: hexGlyph = 7'b0010010;
      4'h6: hexGlyph = 7'b0000010;
      4'h7: hexGlyph = 7'b1111000;
      4'h8: hexGlyph = 7'b0000000;
      4'h9: hexGlyph = 7'b0010000;
      4'hA: hexGlyph = 7'b0001000;
      4'hB: hexGlyph = 7'b0000011;
      4'hC: hexGlyph = 7'b1000110;
      4'hD: hexGlyph = 7'b0100001;
      4'hE: hexGlyph = 7'b0000110;
      default: hexGlyph = 7'b0001110;
    endcase
  endfunction

  // Digit decode is combinational straight off the nibble register.
  for (genvar gi = 0; gi < N_HEX; gi++) begin : gHexDigit
    assign HEX[7*gi +: 7] = hexGlyph(hexReg[4*gi +: 4]);
  end

  // ---------------------------------------------------------------------
  // Key synchronisation and edge detection
  // ---------------------------------------------------------------------
  logic [N_KEYS-1:0] keySync1, keySync2, keyPrev;
  logic [N_KEYS-1:0] keyPressed, keyEdge;
  logic              keyEdgeAny;

  // Two-flop synchroniser (idle high) plus a history flop for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      keySync1 <= '1;
      keySync2 <= '1;
      keyPrev  <= '0;
    end else begin
      keySync1 <= KEY;
      keySync2 <= keySync1;
      keyPrev  <= keyPressed;
    end
  end

  assign keyPressed = ~keySync2;
  assign keyEdge    = keyPressed & ~keyPrev;
  assign keyEdgeAny = |keyEdge;

  // ---------------------------------------------------------------------
  // Switch synchronisation and per-bit debounce
  // ---------------------------------------------------------------------
  logic [N_SW-1:0] swSync1, swSync2, swStable, swStableNext;
  logic [N_SW-1:0] swDiffer, swFire;
  logic [CW-1:0]   swCnt     [N_SW];
  logic [CW-1:0]   swCntNext [N_SW];
  logic            swChange;

  // Each bit counts how long the synchronised value has disagreed with the
  // accepted value; it is accepted only after DEBOUNCE_CYCLES such cycles.
  for (genvar gi = 0; gi < N_SW; gi++) begin : gSwDebounce
    assign swDiffer[gi]     = swSync2[gi] ^ swStable[gi];
    assign swFire[gi]       = swDiffer[gi] && (swCnt[gi] == CNT_LAST);
    assign swCntNext[gi]    = (!swDiffer[gi] || swFire[gi]) ? '0 : CW'(swCnt[gi] + 1'b1);
    assign swStableNext[gi] = swFire[gi] ? swSync2[gi] : swStable[gi];
  end

  assign swChange = |swFire;

  // Switch synchroniser, accepted value and debounce counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      swSync1  <= '0;
      swSync2  <= '0;
      swStable <= '0;
      for (int i = 0; i < N_SW; i++) swCnt[i] <= '0;
    end else begin
      swSync1  <= SW;
      swSync2  <= swSync1;
      swStable <= swStableNext;
      for (int i = 0; i < N_SW; i++) swCnt[i] <= swCntNext[i];
    end
  end

  // ---------------------------------------------------------------------
  // Sticky status registers
  // ---------------------------------------------------------------------
  logic keyReady, keyOvr, keyReadyNext, keyOvrNext;
  logic swReady,  swOvr,  swReadyNext,  swOvrNext;
  logic keyClrLoad, keyOvrStore, swClrLoad, swOvrStore;

  assign keyClrLoad  = re && selKey;
  assign keyOvrStore = we && selKctrl && !wdata[2];
  assign swClrLoad   = re && selSw;
  assign swOvrStore  = we && selSctrl && !wdata[2];

  // An event beats a clearing load for ready; overrun is only raised when
  // the previous event is still unconsumed, and raising beats clearing.
  always_comb begin
    keyReadyNext = keyReady;
    keyOvrNext   = keyOvr;
    swReadyNext  = swReady;
    swOvrNext    = swOvr;

    if (keyEdgeAny)      keyReadyNext = 1'b1;
    else if (keyClrLoad) keyReadyNext = 1'b0;
    if (keyEdgeAny && keyReady && !keyClrLoad) keyOvrNext = 1'b1;
    else if (keyOvrStore)                      keyOvrNext = 1'b0;

    if (swChange)        swReadyNext = 1'b1;
    else if (swClrLoad)  swReadyNext = 1'b0;
    if (swChange && swReady && !swClrLoad) swOvrNext = 1'b1;
    else if (swOvrStore)                   swOvrNext = 1'b0;
  end

  // Status state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      keyReady <= 1'b0;
      keyOvr   <= 1'b0;
      swReady  <= 1'b0;
      swOvr    <= 1'b0;
    end else begin
      keyReady <= keyReadyNext;
      keyOvr   <= keyOvrNext;
      swReady  <= swReadyNext;
      swOvr    <= swOvrNext;
    end
  end

  // ---------------------------------------------------------------------
  // Load data mux
  // ---------------------------------------------------------------------
  // Combinational read; everything zero-extended, zero when idle/unmapped.
  always_comb begin
    rdata = '0;
    if (re) begin
      if (selHex)        rdata = DBITS'(hexReg);
      else if (selLedr)  rdata = DBITS'(ledrReg);
      else if (selKey)   rdata = DBITS'(keyPressed);
      else if (selSw)    rdata = DBITS'(swStable);
      else if (selKctrl) rdata = DBITS'({keyOvr, 1'b0, keyReady});
      else if (selSctrl) rdata = DBITS'({swOvr, 1'b0, swReady});
    end
  end

endmodule

// File: tb/tb_mmio_ui_ctrl.sv
// Directed bench for mmio_ui_ctrl: expected values go into a scoreboard
// queue as each step is issued and are popped when the DUT output is sampled.
module tb_mmio_ui_ctrl;

  localparam int DBITS = 32;
  localparam int N_KEYS = 4;
  localparam int N_SW = 10;
  localparam int N_LEDR = 10;
  localparam int N_HEX = 4;
  localparam int DEB = 16;

  localparam logic [31:0] A_HEX   = 32'hF0000000;
  localparam logic [31:0] A_LEDR  = 32'hF0000004;
  localparam logic [31:0] A_KEY   = 32'hF0000010;
  localparam logic [31:0] A_SW    = 32'hF0000014;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;

  logic               clk = 1'b0;
  logic               reset;
  logic [DBITS-1:0]   addr, wdata, rdata;
  logic               we, re, hit;
  logic [N_KEYS-1:0]  KEY;
  logic [N_SW-1:0]    SW;
  logic [N_LEDR-1:0]  LEDR;
  logic [7*N_HEX-1:0] HEX;

  int total = 0;
  int bad = 0;
  logic [63:0] expQ[$];
  string       tagQ[$];

  mmio_ui_ctrl #(
    .DBITS(DBITS), .N_KEYS(N_KEYS), .N_SW(N_SW), .N_LEDR(N_LEDR),
    .N_HEX(N_HEX), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .hit(hit), .KEY(KEY), .SW(SW), .LEDR(LEDR), .HEX(HEX)
  );

  always #5 clk = ~clk;

  task automatic pushExp(input logic [63:0] e, input string t);
    expQ.push_back(e);
    tagQ.push_back(t);
  endtask

  task automatic compare(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    e = expQ.pop_front();
    t = tagQ.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", t, obs, e);
    end
    $display("check %s: got %0h want %0h", t, obs, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One load cycle: data sampled mid-cycle, side effects at the next edge.
  task automatic readReg(input logic [31:0] a, input logic [31:0] e, input string t);
    pushExp(64'(e), t);
    addr = a;
    re = 1'b1;
    #2;
    compare(64'(rdata));
    @(posedge clk);
    #1;
    re = 1'b0;
    addr = '0;
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    addr = '0;
    wdata = '0;
  endtask

  initial begin
    reset = 1'b1; KEY = '1; SW = '0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    tick(3);
    reset = 1'b0;

    // Reset state
    readReg(A_HEX, 32'h0, "rst_hex");
    readReg(A_LEDR, 32'h0, "rst_ledr");
    readReg(A_KCTRL, 32'h0, "rst_kctrl");
    readReg(A_SCTRL, 32'h0, "rst_sctrl");
    pushExp(64'({G0, G0, G0, G0}), "rst_hex_port");
    compare(64'(HEX));

    // Unmapped address: no hit, reads zero; mapped address hits
    addr = 32'hF0000008; re = 1'b1; #2;
    pushExp(64'h0, "unmapped_rdata"); compare(64'(rdata));
    pushExp(64'h0, "unmapped_hit");   compare(64'(hit));
    addr = A_SCTRL; #1;
    pushExp(64'h1, "mapped_hit");     compare(64'(hit));
    tick(1); re = 1'b0; addr = '0;

    // HEX and LEDR stores
    writeReg(A_HEX, 32'h0000_1234);
    pushExp(64'({G1, G2, G3, G4}), "hex_port_1234");
    compare(64'(HEX));
    readReg(A_HEX, 32'h1234, "hex_read");
    writeReg(A_LEDR, 32'hFFFF_FFF5);
    pushExp(64'h3F5, "ledr_port");
    compare(64'(LEDR));
    readReg(A_LEDR, 32'h3F5, "ledr_read");

    // Single key press: latency, vector read, clear on load
    KEY = 4'b1011;
    tick(2);
    readReg(A_KCTRL, 32'h0, "key_lat_early");
    readReg(A_KCTRL, 32'h1, "key_ready");
    readReg(A_KEY, 32'h4, "key_vec");
    readReg(A_KCTRL, 32'h0, "key_cleared");
    KEY = '1; tick(4);

    // Two presses without reading -> overrun; store 0 clears overrun only
    KEY = 4'b1110; tick(4);
    KEY = 4'b1111; tick(4);
    KEY = 4'b1101; tick(4);
    readReg(A_KCTRL, 32'h5, "key_overrun");
    writeReg(A_KCTRL, 32'h0);
    readReg(A_KCTRL, 32'h1, "ovr_cleared");
    readReg(A_KEY, 32'h2, "key1_vec");
    readReg(A_KCTRL, 32'h0, "key_all_clear");
    KEY = '1; tick(4);

    // Edge coincident with clearing load while ready: ready stays, no overrun
    KEY = 4'b1110; tick(4);
    KEY = 4'b1111; tick(4);
    KEY = 4'b1101; tick(2);
    readReg(A_KEY, 32'h2, "edge_load_vec");
    readReg(A_KCTRL, 32'h1, "edge_load_status");
    readReg(A_KEY, 32'h2, "edge_load_vec2");
    readReg(A_KCTRL, 32'h0, "edge_load_clear");
    KEY = '1; tick(4);

    // Edge coincident with overrun-clearing store, ready already 1 -> kept
    KEY = 4'b1110; tick(4);
    KEY = 4'b1111; tick(4);
    KEY = 4'b1110; tick(4);
    readReg(A_KCTRL, 32'h5, "ovr_setup");
    KEY = 4'b1111; tick(4);
    KEY = 4'b1101; tick(2);
    writeReg(A_KCTRL, 32'h0);
    readReg(A_KCTRL, 32'h5, "edge_store_keep");
    readReg(A_KEY, 32'h2, "edge_store_vec");
    readReg(A_KCTRL, 32'h4, "ovr_only");
    // Same collision with ready==0 -> overrun cleared
    KEY = 4'b1111; tick(4);
    KEY = 4'b1101; tick(2);
    writeReg(A_KCTRL, 32'h0);
    readReg(A_KCTRL, 32'h1, "edge_store_clear");
    readReg(A_KEY, 32'h2, "edge_store_vec2");
    readReg(A_KCTRL, 32'h0, "key_idle");
    KEY = '1; tick(4);

    // Switch glitch one cycle short of the debounce window is rejected
    SW = 10'h008; tick(DEB - 1);
    SW = 10'h000; tick(20);
    readReg(A_SW, 32'h0, "sw_glitch");
    readReg(A_SCTRL, 32'h0, "sctrl_glitch");

    // Held switch accepted exactly DEB+2 edges after the change
    SW = 10'h008; tick(DEB + 1);
    readReg(A_SW, 32'h0, "sw_boundary");
    readReg(A_SCTRL, 32'h1, "sctrl_ready");
    readReg(A_SW, 32'h8, "sw_accepted");
    readReg(A_SCTRL, 32'h0, "sctrl_cleared");

    // Reset mid-debounce discards everything
    SW = 10'h028; tick(8);
    reset = 1'b1; tick(1); reset = 1'b0;
    readReg(A_SW, 32'h0, "rst_mid_sw");
    readReg(A_SCTRL, 32'h0, "rst_mid_sctrl");
    pushExp(64'({G0, G0, G0, G0}), "rst_mid_hex_port");
    compare(64'(HEX));
    readReg(A_LEDR, 32'h0, "rst_mid_ledr");
    // Switches held through reset produce one event DEB+2 edges later
    tick(DEB - 2);
    readReg(A_SCTRL, 32'h0, "post_rst_pre");
    readReg(A_SCTRL, 32'h1, "post_rst_event");
    readReg(A_SW, 32'h28, "post_rst_sw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
